// File: rtl/fifo_pkg.sv
// Shared defaults, pointer-width helper and the registered status-flag bundle for fifo_gen2.
package fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 32;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef struct packed {
      logic empty_n;
      logic full_n;
      logic almost_empty_n;
      logic almost_full_n;
      logic overflow;
      logic underflow;
   } flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
// Read data lands one cycle after the address; the read register holds while re is low.
module fifo_ram #(
   parameter int WIDTH = 8,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];

   // Read-before-write on an address collision: rdata gets the old word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_gen2.sv
// Synchronous FIFO with registered occupancy/flags, sticky error flags and optional first-word-fall-through.
// Read data one cycle after an accepted read (FWFT=0); refused reads/writes set sticky underflow/overflow.
module fifo_gen2
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   write,
   input  logic                   read,
   input  logic                   clear_err,
   output logic [WIDTH-1:0]       data_out,
   output logic [$clog2(DEPTH):0] use_dw,
   output logic                   empty_n,
   output logic                   full_n,
   output logic                   almost_empty_n,
   output logic                   almost_full_n,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int          AW      = ptr_w(DEPTH);
   localparam bit          IS_FWFT = (FWFT != 0);
   localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] FULL_L  = (AW+1)'(DEPTH);
   localparam flags_t      FL_RST  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
      $error("fifo_gen2: DEPTH must be a power of two in 4..1024");
   end
   if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("fifo_gen2: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("fifo_gen2: WIDTH must be in 1..64");
   end

   logic [AW-1:0]    wr_ptr, rd_ptr, ram_raddr;
   logic [AW:0]      use_next;
   logic             rd_acc, wr_acc, ram_we, ram_re;
   logic             out_zero, byp;
   logic [WIDTH-1:0] byp_dat, ram_q;
   flags_t           fl, fl_next;

   assign rd_acc = read & fl.empty_n;
   assign wr_acc = write & (fl.full_n | rd_acc);
   assign ram_we = wr_acc & ~rst;

   // FWFT keeps the read port pointed at the head, pre-fetching the next entry on a read.
   if (IS_FWFT) begin : g_fwft
      assign ram_raddr = rd_acc ? rd_ptr + AW'(1) : rd_ptr;
      assign ram_re    = 1'b1;
   end else begin : g_std
      assign ram_raddr = rd_ptr;
      assign ram_re    = rd_acc;
   end

   fifo_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (data_in),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   always_comb begin
      use_next = use_dw;
      fl_next  = '0;
      if (wr_acc && !rd_acc)      use_next = use_dw + (AW+1)'(1);
      else if (rd_acc && !wr_acc) use_next = use_dw - (AW+1)'(1);
      fl_next.empty_n        = (use_next != '0);
      fl_next.full_n         = (use_next != FULL_L);
      fl_next.almost_empty_n = (use_next > AE_L);
      fl_next.almost_full_n  = (use_next < AF_L);
      // A fresh error wins over a coincident clear.
      fl_next.overflow       = (write & ~wr_acc) | (fl.overflow & ~clear_err);
      fl_next.underflow      = (read & ~rd_acc) | (fl.underflow & ~clear_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         use_dw   <= '0;
         fl       <= FL_RST;
         out_zero <= 1'b1;
         byp      <= 1'b0;
         byp_dat  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         use_dw  <= use_next;
         fl      <= fl_next;
         if (IS_FWFT ? wr_acc : rd_acc) out_zero <= 1'b0;
         // Word written to the address being fetched: forward it since the RAM returns the old word.
         byp     <= IS_FWFT && wr_acc && (wr_ptr == ram_raddr);
         byp_dat <= data_in;
      end
   end

   assign data_out       = out_zero ? '0 : (byp ? byp_dat : ram_q);
   assign empty_n        = fl.empty_n;
   assign full_n         = fl.full_n;
   assign almost_empty_n = fl.almost_empty_n;
   assign almost_full_n  = fl.almost_full_n;
   assign overflow       = fl.overflow;
   assign underflow      = fl.underflow;

endmodule

// File: tb/tb_fifo_gen2.sv
// Scoreboarded bench for fifo_gen2: registered-read instance driven by directed vectors, plus an FWFT instance.
module tb_fifo_gen2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data0, data1;
   logic       write0, read0, clr0, write1, read1, clr1;
   logic [7:0] data_out0, data_out1;
   logic [5:0] use_dw0, use_dw1;
   logic       empty_n0, full_n0, ae_n0, af_n0, ovf0, unf0;
   logic       empty_n1, full_n1, ae_n1, af_n1, ovf1, unf1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   logic       mon_fire;
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   fifo_gen2 dut0 (
      .clk(clk), .rst(rst), .data_in(data0), .write(write0), .read(read0), .clear_err(clr0),
      .data_out(data_out0), .use_dw(use_dw0), .empty_n(empty_n0), .full_n(full_n0),
      .almost_empty_n(ae_n0), .almost_full_n(af_n0), .overflow(ovf0), .underflow(unf0)
   );

   fifo_gen2 #(.FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .data_in(data1), .write(write1), .read(read1), .clear_err(clr1),
      .data_out(data_out1), .use_dw(use_dw1), .empty_n(empty_n1), .full_n(full_n1),
      .almost_empty_n(ae_n1), .almost_full_n(af_n1), .overflow(ovf1), .underflow(unf1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle on dut0 and advance the reference model; returns on the following negedge.
   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic clr, input logic rs);
      logic rd_ok, wr_ok;
      write0 = w; read0 = r; data0 = d; clr0 = clr; rst = rs;
      if (rs) begin
         model_q.delete();
      end else begin
         rd_ok = r && (model_q.size() > 0);
         wr_ok = w && ((model_q.size() < 32) || rd_ok);
         if (rd_ok) exp_q.push_back(model_q.pop_front());
         if (wr_ok) model_q.push_back(d);
      end
      @(negedge clk);
   endtask

   // Monitor: every read dut0 accepts must produce the next expected word one cycle later.
   always begin
      @(posedge clk);
      mon_fire = read0 && empty_n0 && !rst;
      #1;
      if (mon_fire) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_data: got %0h with no read expected", data_out0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("rd_data", {24'd0, data_out0}, {24'd0, mon_exp});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; write0 = 0; read0 = 0; clr0 = 0; data0 = '0;
      write1 = 0; read1 = 0; clr1 = 0; data1 = '0;
      @(negedge clk);
      step(0, 0, 8'h00, 0, 1);
      chk("rst_use_dw", use_dw0, 0);
      chk("rst_empty_n", empty_n0, 0);
      chk("rst_full_n", full_n0, 1);
      chk("rst_ae_n", ae_n0, 0);
      chk("rst_af_n", af_n0, 1);
      chk("rst_ovf", ovf0, 0);
      chk("rst_unf", unf0, 0);
      chk("rst_data_out", data_out0, 0);
      chk("rst_data_out_fwft", data_out1, 0);
      chk("rst_empty_n_fwft", empty_n1, 0);

      // Fill 0x00..0x1F, checking occupancy and thresholds at each level.
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 8'(i), 0, 0);
         chk("fill_use_dw", use_dw0, i + 1);
         chk("fill_full_n", full_n0, (i + 1 < 32) ? 1 : 0);
         chk("fill_af_n", af_n0, (i + 1 < 28) ? 1 : 0);
         chk("fill_ae_n", ae_n0, (i + 1 > 4) ? 1 : 0);
      end

      step(1, 0, 8'hAA, 0, 0);
      chk("ovf_set", ovf0, 1);
      chk("ovf_use_dw", use_dw0, 32);
      step(1, 0, 8'hAB, 1, 0);
      chk("ovf_clear_vs_new", ovf0, 1);
      step(0, 0, 8'h00, 1, 0);
      chk("ovf_cleared", ovf0, 0);

      for (int i = 0; i < 32; i++) begin
         step(0, 1, 8'h00, 0, 0);
         chk("drain_use_dw", use_dw0, 31 - i);
      end
      chk("drain_empty_n", empty_n0, 0);
      step(0, 1, 8'h00, 0, 0);
      chk("unf_set", unf0, 1);
      chk("unf_data_hold", data_out0, 8'h1F);
      step(0, 0, 8'h00, 1, 0);
      chk("unf_cleared", unf0, 0);

      // Read+write on empty: read refused, write lands.
      step(1, 1, 8'h40, 0, 0);
      chk("rw_empty_unf", unf0, 1);
      chk("rw_empty_use_dw", use_dw0, 1);
      chk("rw_empty_empty_n", empty_n0, 1);
      step(0, 0, 8'h00, 1, 0);

      for (int i = 1; i < 32; i++) step(1, 0, 8'h40 + 8'(i), 0, 0);
      chk("refill_full_n", full_n0, 0);

      // Read+write while full for 40 cycles: pointers wrap, order kept.
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 8'h80 + 8'(i), 0, 0);
         chk("rw_full_use_dw", use_dw0, 32);
         chk("rw_full_full_n", full_n0, 0);
      end
      chk("rw_full_no_ovf", ovf0, 0);
      for (int i = 0; i < 32; i++) step(0, 1, 8'h00, 0, 0);
      chk("final_empty_n", empty_n0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      // Reset with read+write pending at use_dw=10.
      step(0, 1, 8'h00, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 8'hC0 + 8'(i), 0, 0);
      chk("pre_rst_use_dw", use_dw0, 10);
      chk("pre_rst_unf", unf0, 1);
      step(1, 1, 8'hEE, 0, 1);
      chk("mid_rst_use_dw", use_dw0, 0);
      chk("mid_rst_empty_n", empty_n0, 0);
      chk("mid_rst_unf", unf0, 0);
      chk("mid_rst_ovf", ovf0, 0);
      chk("mid_rst_data_out", data_out0, 0);
      step(0, 0, 8'h00, 0, 0);
      chk("post_rst_use_dw", use_dw0, 0);
      chk("post_rst_empty_n", empty_n0, 0);

      // FWFT instance.
      write1 = 1; data1 = 8'h3C;
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_empty_n", empty_n1, 1);
      chk("fwft_first", data_out1, 8'h3C);
      data1 = 8'h3D;
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_head_hold", data_out1, 8'h3C);
      chk("fwft_use_dw2", use_dw1, 2);
      write1 = 0; read1 = 1;
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_next", data_out1, 8'h3D);
      chk("fwft_use_dw1", use_dw1, 1);
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_drained", empty_n1, 0);
      read1 = 0; write1 = 1; data1 = 8'h11;
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_refill", data_out1, 8'h11);
      read1 = 1; data1 = 8'h22;
      step(0, 0, 8'h00, 0, 0);
      chk("fwft_rw_one", data_out1, 8'h22);
      chk("fwft_rw_use_dw", use_dw1, 1);
      read1 = 0; write1 = 0;
      step(0, 0, 8'h00, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
